// File: rtl/reversible_div_pkg.sv
// reversible_div_pkg: shared widths and FSM state type for the reversible divider.
package reversible_div_pkg;
    localparam int DIVIDEND_W = 12;
    localparam int DIVISOR_W = 6;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/reversible_7bit_subtractor.sv
// reversible_7bit_subtractor: a - b as a ripple of reversible full adders (b inverted, carry-in 1).
module reversible_7bit_subtractor #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);
    logic [W:0] c;
    logic [W-1:0] bn, p;
    assign c[0] = 1'b1;
    assign bn = ~b;
    // Each stage is two cascaded Peres gates: propagate, then sum and carry.
    for (genvar i = 0; i < W; i++) begin : g_rfa
        assign p[i] = a[i] ^ bn[i];
        assign diff[i] = p[i] ^ c[i];
        assign c[i+1] = (a[i] & bn[i]) ^ (c[i] & p[i]);
    end
    assign no_borrow = c[W];
endmodule

// File: rtl/reversible_6bit_divider.sv
// reversible_6bit_divider: restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor straight to DONE and flag div_by_zero.
module reversible_6bit_divider
    import reversible_div_pkg::*;
#(
    parameter int DIVIDEND_W = reversible_div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = reversible_div_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [DIVIDEND_W-1:0] dq;
    logic [DIVISOR_W-1:0] dvs, r, r_nx;
    logic [DIVISOR_W:0] r_sh, diff;
    logic nb, accept, last, fast_zero, zero_pend, diff_msb_unused;

    assign busy = state == RUN;
    assign done = state == DONE;
    assign accept = start && state != RUN && !zero_pend;
    assign last = cnt == CNT_W'(DIVIDEND_W - 1);
    // dq shifts the dividend out at the top while quotient bits enter at the bottom.
    assign r_sh = {r, dq[DIVIDEND_W-1]};
    assign r_nx = nb ? diff[DIVISOR_W-1:0] : r_sh[DIVISOR_W-1:0];
    assign diff_msb_unused = diff[DIVISOR_W];

    reversible_7bit_subtractor #(.W(DIVISOR_W + 1)) u_sub (
        .a(r_sh),
        .b({1'b0, dvs}),
        .diff(diff),
        .no_borrow(nb)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = state == RUN ? (last ? DONE : RUN)
                 : zero_pend ? DONE
                 : (accept && !fast_zero) ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            dq <= '0;
            dvs <= '0;
            r <= '0;
            quotient <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt <= '0;
            dq <= dividend;
            dvs <= divisor;
            r <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            dq <= {dq[DIVIDEND_W-2:0], nb};
            r <= r_nx;
            if (last) begin
                quotient <= {dq[DIVIDEND_W-2:0], nb};
                remainder <= r_nx;
            end
        end else if (zero_pend) begin
            quotient <= '1;
            remainder <= dq[DIVISOR_W-1:0];
        end

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = divisor == '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            zero_pend <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            zero_pend <= accept && fast_zero;
            div_by_zero <= zero_pend || (div_by_zero && !accept);
        end
`else
    assign fast_zero = 1'b0;
    assign zero_pend = 1'b0;
    assign div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_reversible_6bit_divider.sv
// tb_reversible_6bit_divider: directed vectors with hand-computed results for the divider.
module tb_reversible_6bit_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [11:0] dividend = '0;
    logic [5:0] divisor = '0;
    logic busy, done, div_by_zero;
    logic [11:0] quotient;
    logic [5:0] remainder;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
    localparam logic ZDBZ = 1'b1;
    localparam logic ZBUSY = 1'b0;
`else
    localparam int ZLAT = 12;
    localparam logic ZDBZ = 1'b0;
    localparam logic ZBUSY = 1'b1;
`endif

    reversible_6bit_divider dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [11:0] a, input logic [5:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, cyc - t0, exp_lat);
    endtask

    task automatic div_case(input string tag, input logic [11:0] a, input logic [5:0] b,
                            input logic [11:0] q, input logic [5:0] r);
        do_start(a, b);
        wait_done(tag, 12);
        check({tag, "_q"}, quotient, q);
        check({tag, "_r"}, remainder, r);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic count_dones(input string tag, input int n);
        int d = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            d += int'(done);
        end
        check(tag, d, 0);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        step(2);

        do_start(12'd200, 6'd7);
        check("basic_busy", busy, 1);
        wait_done("basic", 12);
        check("basic_q", quotient, 28);
        check("basic_r", remainder, 4);
        check("basic_dbz", div_by_zero, 0);
        step(1);
        check("basic_pulse", done, 0);
        check("basic_hold", quotient, 28);

        div_case("max", 12'd4095, 6'd1, 12'd4095, 6'd0);
        div_case("eq", 12'd63, 6'd63, 12'd1, 6'd0);
        div_case("zero_dvd", 12'd0, 6'd5, 12'd0, 6'd0);

        do_start(12'hABC, 6'd0);
        check("dz_busy", busy, ZBUSY);
        wait_done("dz", ZLAT);
        check("dz_q", quotient, 12'hFFF);
        check("dz_r", remainder, 6'h3C);
        check("dz_dbz", div_by_zero, ZDBZ);
        step(2);
        do_start(12'd100, 6'd3);
        check("dz_clear", div_by_zero, 0);
        step(4);
        start = 1'b1;
        dividend = 12'd50;
        divisor = 6'd2;
        step(1);
        start = 1'b0;
        check("busy_q_held", quotient, 12'hFFF);
        wait_done("busy", 12);
        check("busy_q", quotient, 33);
        check("busy_r", remainder, 1);
        count_dones("busy_no_second", 20);

        do_start(12'd200, 6'd7);
        wait_done("b2b_first", 12);
        do_start(12'd77, 6'd9);
        check("b2b_done_low", done, 0);
        check("b2b_busy", busy, 1);
        step(6);
        check("b2b_hold_q", quotient, 28);
        check("b2b_hold_r", remainder, 4);
        wait_done("b2b", 12);
        check("b2b_q", quotient, 8);
        check("b2b_r", remainder, 5);

        do_start(12'd200, 6'd7);
        step(6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        step(1);
        #2;
        rst_n = 1'b1;
        step(1);
        count_dones("arst_no_done", 20);
        div_case("post_rst", 12'd100, 6'd3, 12'd33, 6'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
